// File: rtl/single_clk_byte_ram_if.sv
// Write/read port bundle for single_clk_byte_ram: one write port with byte enables
// and one read port with registered data.
interface single_clk_byte_ram_if #(
  parameter int ADDW = 16,
  parameter int DATW = 32
);
  logic [DATW-1:0]   d;
  logic [ADDW-1:0]   wr_addr;
  logic [DATW/8-1:0] we;
  logic [ADDW-1:0]   rd_addr;
  logic [DATW-1:0]   q;

  modport master (output d, wr_addr, we, rd_addr, input q);
  modport slave  (input d, wr_addr, we, rd_addr, output q);
endinterface

// File: rtl/single_clk_byte_ram.sv
// Single-clock simple dual-port RAM with byte-lane write enables and a registered
// read port; written in the block-RAM inference pattern.
module single_clk_byte_ram #(
  parameter int ADDW         = 16,
  parameter int DATW         = 32,
  parameter bit RDW_NEW_DATA = 1'b0
) (
  input logic                 clk,
  input logic                 reset_n,
  single_clk_byte_ram_if.slave bus
);
  localparam int NB    = DATW / 8;
  localparam int DEPTH = 1 << ADDW;

  if ((DATW % 8) != 0) begin : g_bad_datw
    $error("single_clk_byte_ram: DATW must be a multiple of 8");
  end

  logic [DATW-1:0] mem [0:DEPTH-1];
  logic [DATW-1:0] rd_word;
  logic [DATW-1:0] q_p1;

  // Write stage: reset suppresses writes; an X enable bit never qualifies as a write.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.we[k] == 1'b1) begin
          mem[bus.wr_addr][8*k +: 8] <= bus.d[8*k +: 8];
        end
      end
    end
  end

  if (RDW_NEW_DATA) begin : g_rdw_new
    always_comb begin
      rd_word = mem[bus.rd_addr];
      if (bus.rd_addr == bus.wr_addr) begin
        for (int k = 0; k < NB; k++) begin
          if (bus.we[k] == 1'b1) begin
            rd_word[8*k +: 8] = bus.d[8*k +: 8];
          end
        end
      end
    end
  end else begin : g_rdw_old
    always_comb begin
      rd_word = mem[bus.rd_addr];
    end
  end

  // Read output register (p1): one cycle from rd_addr to q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_p1 <= '0;
    end else begin
      q_p1 <= rd_word;
    end
  end

  assign bus.q = q_p1;
endmodule

// File: tb/tb_single_clk_byte_ram.sv
// Directed bench for single_clk_byte_ram: one instance per read-during-write mode,
// both driven with identical stimulus.
module tb_single_clk_byte_ram;
  localparam int ADDW = 16;
  localparam int DATW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [DATW-1:0] d;
  logic [ADDW-1:0] wr_addr;
  logic [3:0]      we;
  logic [ADDW-1:0] rd_addr;
  logic [DATW-1:0] q0, q1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  single_clk_byte_ram_if #(.ADDW(ADDW), .DATW(DATW)) bus0 ();
  single_clk_byte_ram_if #(.ADDW(ADDW), .DATW(DATW)) bus1 ();

  assign bus0.d = d;  assign bus0.wr_addr = wr_addr;  assign bus0.we = we;  assign bus0.rd_addr = rd_addr;
  assign bus1.d = d;  assign bus1.wr_addr = wr_addr;  assign bus1.we = we;  assign bus1.rd_addr = rd_addr;
  assign q0 = bus0.q;
  assign q1 = bus1.q;

  single_clk_byte_ram #(.ADDW(ADDW), .DATW(DATW), .RDW_NEW_DATA(1'b0)) dut_old (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  single_clk_byte_ram #(.ADDW(ADDW), .DATW(DATW), .RDW_NEW_DATA(1'b1)) dut_new (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDW-1:0] a, input logic [DATW-1:0] v, input logic [3:0] en);
    wr_addr = a; d = v; we = en;
    tick();
    we = 4'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; we = 4'hF; wr_addr = '0; d = 32'hDEADBEEF; rd_addr = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (q0 !== 32'h0 || q1 !== 32'h0) begin
        fails++;
        $display("FAIL reset_q cycle %0d: q_old=%h q_new=%h expected 00000000", i, q0, q1);
      end
    end
    we = 4'h0;
    reset_n = 1'b1;
    tick();
    tick();
    tests++;
    if (q0 === 32'hDEADBEEF || q1 === 32'hDEADBEEF) begin
      fails++;
      $display("FAIL reset_write_suppressed: q_old=%h q_new=%h must not be deadbeef", q0, q1);
    end
  endtask

  task automatic test_full_word();
    wr(16'h0010, 32'h12345678, 4'hF);
    rd_addr = 16'h0010;
    tick();
    tests++;
    if (q0 !== 32'h12345678 || q1 !== 32'h12345678) begin
      fails++;
      $display("FAIL full_word: q_old=%h q_new=%h expected 12345678", q0, q1);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDW-1:0] addrs [3];
    logic [DATW-1:0] exp   [3];
    addrs[0] = 16'h0000; exp[0] = 32'h01020304;
    addrs[1] = 16'h0010; exp[1] = 32'h12345678;
    addrs[2] = 16'hFFFF; exp[2] = 32'h0BADF00D;
    rd_addr = 16'h1234;
    wr(16'h0000, 32'h01020304, 4'hF);
    wr(16'hFFFF, 32'h0BADF00D, 4'hF);
    rd_addr = addrs[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) rd_addr = addrs[i+1];
      tests++;
      if (q0 !== exp[i] || q1 !== exp[i]) begin
        fails++;
        $display("FAIL stream_read[%0d]: q_old=%h q_new=%h expected %h", i, q0, q1, exp[i]);
      end
    end
  endtask

  task automatic test_byte_enables();
    rd_addr = 16'h0000;
    wr(16'h0020, 32'hAABBCCDD, 4'hF);
    wr(16'h0020, 32'h11223344, 4'b0101);
    rd_addr = 16'h0020;
    tick();
    tests++;
    if (q0 !== 32'hAA22CC44 || q1 !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL byte_enable_merge: q_old=%h q_new=%h expected aa22cc44", q0, q1);
    end
    wr(16'h0020, 32'hFFFFFFFF, 4'b0000);
    tick();
    tests++;
    if (q0 !== 32'hAA22CC44 || q1 !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL we_zero_no_write: q_old=%h q_new=%h expected aa22cc44", q0, q1);
    end
  endtask

  task automatic test_rdw();
    rd_addr = 16'h0000;
    wr(16'h0030, 32'h0, 4'hF);
    rd_addr = 16'h0030;
    wr(16'h0030, 32'hCAFEF00D, 4'hF);
    tests++;
    if (q0 !== 32'h00000000) begin
      fails++;
      $display("FAIL rdw_old_same_edge: q=%h expected 00000000", q0);
    end
    tests++;
    if (q1 !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL rdw_new_same_edge: q=%h expected cafef00d", q1);
    end
    tick();
    tests++;
    if (q0 !== 32'hCAFEF00D || q1 !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL rdw_next_edge: q_old=%h q_new=%h expected cafef00d", q0, q1);
    end
    wr(16'h0030, 32'h0, 4'hF);
    wr(16'h0030, 32'hCAFEF00D, 4'b1000);
    tests++;
    if (q1 !== 32'hCA000000 || q0 !== 32'h00000000) begin
      fails++;
      $display("FAIL rdw_partial: q_old=%h q_new=%h expected 00000000/ca000000", q0, q1);
    end
  endtask

  task automatic test_independence();
    rd_addr = 16'h0010;
    wr(16'hFFFF, 32'h5A5A5A5A, 4'hF);
    tests++;
    if (q0 !== 32'h12345678 || q1 !== 32'h12345678) begin
      fails++;
      $display("FAIL diff_addr_read: q_old=%h q_new=%h expected 12345678", q0, q1);
    end
    rd_addr = 16'hFFFF;
    tick();
    tests++;
    if (q0 !== 32'h5A5A5A5A || q1 !== 32'h5A5A5A5A) begin
      fails++;
      $display("FAIL top_address: q_old=%h q_new=%h expected 5a5a5a5a", q0, q1);
    end
  endtask

  task automatic test_reset_midstream();
    rd_addr = 16'h0010;
    tick();
    tests++;
    if (q0 !== 32'h12345678 || q1 !== 32'h12345678) begin
      fails++;
      $display("FAIL pre_reset_stream: q_old=%h q_new=%h expected 12345678", q0, q1);
    end
    reset_n = 1'b0;
    tick();
    tests++;
    if (q0 !== 32'h0 || q1 !== 32'h0) begin
      fails++;
      $display("FAIL midstream_reset_q: q_old=%h q_new=%h expected 00000000", q0, q1);
    end
    reset_n = 1'b1;
    tick();
    tests++;
    if (q0 !== 32'h12345678 || q1 !== 32'h12345678) begin
      fails++;
      $display("FAIL post_reset_read: q_old=%h q_new=%h expected 12345678", q0, q1);
    end
    rd_addr = 16'h0020;
    tick();
    tests++;
    if (q0 !== 32'hAA22CC44 || q1 !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL contents_retained: q_old=%h q_new=%h expected aa22cc44", q0, q1);
    end
  endtask

  initial begin
    reset_n = 1'b0; d = '0; wr_addr = '0; we = '0; rd_addr = '0;
    #1;
    test_reset();
    test_full_word();
    test_back_to_back();
    test_byte_enables();
    test_rdw();
    test_independence();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/single_clk_byte_ram.md
Name: single_clk_byte_ram

Overview:
- Single-clock, simple dual-port RAM: one write port and one read port, both on the same clock.
- Byte-lane write enables; registered read data with one cycle of latency.
- Used as backing store behind Avalon memory-mapped slave and streaming fetch logic, which present independent read and write addresses.

Parameters:
ADDW, 16, address width in bits; depth = 2**ADDW words.
DATW, 32, data word width in bits; must be a multiple of 8 (elaboration error otherwise).
RDW_NEW_DATA, 0, same-address read-during-write: 0 returns old word, 1 returns newly written bytes merged with unwritten old bytes.

Ports:
clk  input  1  clock; all activity on rising edge.
reset_n  input  1  synchronous active-low reset.
d  input  DATW  write data.
wr_addr  input  ADDW  write word address.
we  input  DATW/8  per-byte write enables; bit k covers d[8k+7:8k].
rd_addr  input  ADDW  read word address, sampled every cycle (no read strobe).
q  output  DATW  registered read data.

Behaviour:
- Reset is synchronous: on a rising edge with reset_n=0, q <= 0 and all writes that cycle are suppressed.
- Memory array contents are never cleared by reset.
- Power-up contents are undefined; consumers must write before reading.
- Write: on a rising edge with reset_n=1, for each k with we[k]=1, mem[wr_addr] byte k <= d byte k. Bytes with we[k]=0 are unchanged.
- we=0 performs no write. Any nonzero we pattern is legal, including partial and non-contiguous patterns.
- Read: on every rising edge with reset_n=1, q <= mem[rd_addr]. Latency is exactly 1 cycle from rd_addr to q.
- q holds its value only if rd_addr and the addressed contents are stable; there is no read enable.
- Read-during-write, rd_addr == wr_addr in the same cycle:
  - RDW_NEW_DATA=0: q shows the pre-write word; the new data is visible on the next read.
  - RDW_NEW_DATA=1: q shows, per byte, d when we[k]=1, else the old byte.
- Read and write at different addresses in the same cycle do not interact.
- Address wrap: addresses are exactly ADDW bits, so there is no out-of-range case. Address 2**ADDW-1 is a valid word.
- Reset asserted mid-stream: q goes to 0 on that edge. The first valid read after release appears one edge after reset_n returns high.
- No X propagation from we into the array: a write occurs only when we[k] is exactly 1.
- Implementation must infer block RAM (registered-output pattern). The read mux must not be built from registers for large ADDW.

Test Plan:
1. Hold reset_n=0 for 2 cycles with we=4'hF, wr_addr=0, d=32'hDEADBEEF -> q=0 throughout. After release, reading address 0 without a prior write shows no DEADBEEF (write suppressed), and q is defined only after a real write.
2. Full-word write then read, ADDW=16, DATW=32: write 32'h12345678 to 0x0010, next cycle rd_addr=0x0010 -> q=32'h12345678 exactly one edge later. Back-to-back reads of 0x0000/0x0010/0xFFFF stream with 1-cycle latency.
3. Byte enables: write 32'hAABBCCDD to 0x0020, then write 32'h11223344 with we=4'b0101 -> reading 0x0020 gives 32'hAA22CC44. A write with we=4'b0000 leaves it unchanged.
4. Read-during-write, address 0x0030 holding 32'h0:
   - RDW_NEW_DATA=0, write 32'hCAFEF00D with rd_addr=wr_addr -> q=32'h00000000 that edge, 32'hCAFEF00D on the following edge.
   - RDW_NEW_DATA=1 -> q=32'hCAFEF00D on the same edge.
   - RDW_NEW_DATA=1, we=4'b1000 -> q=32'hCA000000.
5. Top address and independence: write 32'h5A5A5A5A to 0xFFFF while reading 0x0010 in the same cycle -> q=32'h12345678. Then read 0xFFFF -> 32'h5A5A5A5A.
6. Reset mid-stream: streaming reads of 0x0010 with reset_n pulsed low for one cycle -> q=0 for that edge, 32'h12345678 on the first edge after release. Array contents remain intact.
